param_mux: RTL and testbench



---
 rtl/param_mux.sv | 91 +++++++++
 tb/tb_param_mux.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/param_mux.sv
// rtl/param_mux.sv - 2/3-way SIZE-bit datapath mux with a sticky illegal-select flag.
// Optional output register when MUX_OUT_REG_EN is defined.
module param_mux #(
   parameter int SIZE   = 16,
   parameter int IS3WAY = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [(IS3WAY != 0 ? 2 : 1)-1:0] sel,
   input  logic [SIZE-1:0]               in1,
   input  logic [SIZE-1:0]               in2,
   input  logic [SIZE-1:0]               in3,
   output logic [SIZE-1:0]               out,
   output logic                          sel_err
);

   logic [SIZE-1:0] out_d;

   generate
      if (SIZE < 1 || SIZE > 64) begin : g_bad_size
         $error("param_mux: SIZE=%0d outside 1..64", SIZE);
      end
      if (IS3WAY != 0 && IS3WAY != 1) begin : g_bad_mode
         $error("param_mux: IS3WAY=%0d must be 0 or 1", IS3WAY);
      end
   endgenerate

   generate
      if (IS3WAY == 1) begin : g_3way
         logic sel_err_d;
         logic sel_err_q;

         // Unknown or illegal codes fall through to in1.
         always_comb begin
            out_d = in1;
            case (sel)
               2'b01:   out_d = in3;
               2'b10:   out_d = in2;
               default: out_d = in1;
            endcase
         end

         always_comb begin
            sel_err_d = sel_err_q;
            if (sel == 2'b11) begin
               sel_err_d = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sel_err_q <= 1'b0;
            end else begin
               sel_err_q <= sel_err_d;
            end
         end

         assign sel_err = sel_err_q;
      end else begin : g_2way
         logic unused_sigs;

         always_comb begin
            out_d = in1;
            if (sel == 1'b1) begin
               out_d = in2;
            end
         end

         // in3 exists only to keep a uniform port list; nothing is monitored in 2-way mode.
         assign unused_sigs = ^{in3, clk, rst_n};
         assign sel_err     = 1'b0;
      end
   endgenerate

`ifdef MUX_OUT_REG_EN
   logic [SIZE-1:0] out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;
`else
   assign out = out_d;
`endif

endmodule

// File: tb/tb_param_mux.sv
// tb/tb_param_mux.sv - randomized and directed checks of param_mux against a table-driven model.
module tb_param_mux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel3;
   logic        sel2;
   logic [15:0] in1, in2, in3;
   logic [1:0]  in1s, in2s, in3s;
   logic [15:0] out3, out2;
   logic [1:0]  outs;
   logic        err3, err2, errs;

   int          checks = 0;
   int          errors = 0;
   logic        exp_err;
   logic [15:0] prev3, prev2;
   logic [1:0]  prevs;

   always #5 clk = ~clk;

   param_mux #(.SIZE(16), .IS3WAY(1)) u_mux3 (
      .clk(clk), .rst_n(rst_n), .sel(sel3), .in1(in1), .in2(in2), .in3(in3),
      .out(out3), .sel_err(err3)
   );

   param_mux #(.SIZE(16), .IS3WAY(0)) u_mux2 (
      .clk(clk), .rst_n(rst_n), .sel(sel2), .in1(in1), .in2(in2), .in3(in3),
      .out(out2), .sel_err(err2)
   );

   param_mux #(.SIZE(2), .IS3WAY(0)) u_muxs (
      .clk(clk), .rst_n(rst_n), .sel(sel2), .in1(in1s), .in2(in2s), .in3(in3s),
      .out(outs), .sel_err(errs)
   );

   function automatic logic [15:0] model3(input logic [1:0] s, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
      logic [15:0] pick [4];
      pick = '{a, c, b, a};
      return pick[s];
   endfunction

   function automatic logic [15:0] model2(input logic s, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] pick [2];
      pick = '{a, b};
      return pick[s];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] s3, input logic s2,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      sel3 = s3;
      sel2 = s2;
      in1  = a;
      in2  = b;
      in3  = c;
      in1s = a[1:0];
      in2s = b[1:0];
      in3s = c[1:0];
   endtask

   // Drive at a falling edge, check the outputs, take one rising edge, check again.
   task automatic step(input string tag, input logic [1:0] s3, input logic s2,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      logic [15:0] e3, e2, es;
      drive(s3, s2, a, b, c);
      e3 = model3(s3, a, b, c);
      e2 = model2(s2, a, b);
      es = model2(s2, {14'd0, a[1:0]}, {14'd0, b[1:0]});
      #1;
`ifdef MUX_OUT_REG_EN
      chk({tag, "_hold3"}, out3, prev3);
      chk({tag, "_hold2"}, out2, prev2);
      chk({tag, "_holds"}, outs, prevs);
`else
      chk({tag, "_out3"}, out3, e3);
      chk({tag, "_out2"}, out2, e2);
      chk({tag, "_outs"}, outs, es[1:0]);
`endif
      @(posedge clk);
      if (s3 == 2'b11) exp_err = 1'b1;
      #1;
      chk({tag, "_out3_edge"}, out3, e3);
      chk({tag, "_out2_edge"}, out2, e2);
      chk({tag, "_outs_edge"}, outs, es[1:0]);
      chk({tag, "_err3"}, err3, exp_err);
      chk({tag, "_err2"}, err2, 1'b0);
      chk({tag, "_errs"}, errs, 1'b0);
      prev3 = e3;
      prev2 = e2;
      prevs = es[1:0];
      @(negedge clk);
   endtask

   task automatic pulse_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      exp_err = 1'b0;
      chk({tag, "_err3_rst"}, err3, 1'b0);
`ifdef MUX_OUT_REG_EN
      chk({tag, "_out3_rst"}, out3, 16'h0000);
      chk({tag, "_out2_rst"}, out2, 16'h0000);
      prev3 = '0;
      prev2 = '0;
      prevs = '0;
`else
      chk({tag, "_out3_rst"}, out3, model3(sel3, in1, in2, in3));
      chk({tag, "_out2_rst"}, out2, model2(sel2, in1, in2));
`endif
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      exp_err = 1'b0;
      prev3   = '0;
      prev2   = '0;
      prevs   = '0;
      drive(2'b00, 1'b0, 16'h000F, 16'h00F1, 16'h0F02);
      #2;
      chk("reset_err3", err3, 1'b0);
      chk("reset_err2", err2, 1'b0);
`ifdef MUX_OUT_REG_EN
      chk("reset_out3", out3, 16'h0000);
      chk("reset_out2", out2, 16'h0000);
      chk("reset_outs", outs, 2'b00);
`else
      chk("reset_out3", out3, 16'h000F);
      chk("reset_out2", out2, 16'h000F);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      step("s00",  2'b00, 1'b0, 16'h000F, 16'h00F1, 16'h0F02);
      step("s10",  2'b10, 1'b1, 16'h000F, 16'h00F1, 16'h0F02);
      step("s01",  2'b01, 1'b1, 16'h000F, 16'h00F1, 16'h0F02);
      step("in3ff", 2'b01, 1'b1, 16'h000F, 16'h00F1, 16'hFFFF);
      step("in3ff0", 2'b10, 1'b0, 16'h000F, 16'h00F1, 16'hFFFF);
      step("small0", 2'b00, 1'b0, 16'h0003, 16'h0001, 16'h0002);
      step("small1", 2'b00, 1'b1, 16'h0003, 16'h0001, 16'h0002);

      chk("err_pre", err3, 1'b0);
      step("s11",  2'b11, 1'b0, 16'h000F, 16'h00F1, 16'h0F02);
      step("back00", 2'b00, 1'b0, 16'h000F, 16'h00F1, 16'h0F02);
      pulse_reset("mid");
      step("post_rst", 2'b10, 1'b1, 16'h000F, 16'h00F1, 16'h0F02);

      for (int i = 0; i < 60; i++) begin
         step("rnd", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              16'($urandom), 16'($urandom), 16'($urandom));
         if (i % 15 == 14) pulse_reset("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
